// File: rtl/flex_counter_mode_if.sv
// Control/status bundle for flex_counter_mode: the requester drives the
// counter controls and ring configuration, the counter returns count and status.
interface flex_counter_mode_if #(
  parameter int NUM_CNT_BITS = 8
) ();
  logic                    clear;
  logic                    load;
  logic [NUM_CNT_BITS-1:0] load_val;
  logic                    count_enable;
  logic                    count_up;
  logic                    wrap_mode;
  logic [NUM_CNT_BITS-1:0] step_val;
  logic [NUM_CNT_BITS-1:0] rollover_val;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    rollover_flag;
  logic                    wrap_pulse;
  logic                    saturated;

  modport master (
    output clear, load, load_val, count_enable, count_up, wrap_mode,
           step_val, rollover_val,
    input  count_out, rollover_flag, wrap_pulse, saturated
  );

  modport slave (
    input  clear, load, load_val, count_enable, count_up, wrap_mode,
           step_val, rollover_val,
    output count_out, rollover_flag, wrap_pulse, saturated
  );
endinterface

// File: rtl/flex_counter_mode.sv
// Flexible up/down counter over the ring 1..R with programmable step,
// synchronous load, wrap or saturate behaviour, and registered status.
module flex_counter_mode #(
  parameter int NUM_CNT_BITS = 8
) (
  input logic                 clk,
  input logic                 rst,
  flex_counter_mode_if.slave  bus
);
  localparam int W = NUM_CNT_BITS;

  logic [W-1:0] count_q;
  logic         flag_q;
  logic         wrap_q;
  logic         sat_q;

  logic [W-1:0] cnt_nxt;
  logic         wrap_nxt;
  logic         sat_nxt;
  logic [W-1:0] s_eff;
  logic [W:0]   c_w;
  logic [W:0]   r_w;
  logic [W:0]   s_w;
  logic [W:0]   sum_w;
  logic [W:0]   cp_w;
  logic [W:0]   res_w;

  // Step of zero means one; a step beyond the ring is limited to R.
  function automatic logic [W-1:0] eff_step(input logic [W-1:0] step,
                                            input logic [W-1:0] r);
    logic [W-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    if (step == '0)    return one;
    else if (step > r) return r;
    else               return step;
  endfunction

  // Loads never place the count outside the ring.
  function automatic logic [W-1:0] clamp_to_ring(input logic [W-1:0] v,
                                                 input logic [W-1:0] r);
    return (v > r) ? r : v;
  endfunction

  // Next-state decode; all arithmetic is one bit wider than the count so
  // c+s and c'+R-s never overflow.
  always_comb begin
    cnt_nxt  = count_q;
    wrap_nxt = 1'b0;
    sat_nxt  = sat_q;
    s_eff    = eff_step(bus.step_val, bus.rollover_val);
    c_w      = {1'b0, count_q};
    r_w      = {1'b0, bus.rollover_val};
    s_w      = {1'b0, s_eff};
    sum_w    = c_w + s_w;
    cp_w     = (count_q == '0) ? r_w : c_w;
    res_w    = '0;
    if (bus.clear) begin
      cnt_nxt = '0;
      sat_nxt = 1'b0;
    end else if (bus.load) begin
      cnt_nxt = clamp_to_ring(bus.load_val, bus.rollover_val);
      sat_nxt = 1'b0;
    end else if (bus.count_enable && (bus.rollover_val != '0)) begin
      if (c_w > r_w) begin
        // Count stranded above a lowered R: re-enter the ring regardless of direction.
        if (bus.wrap_mode) begin
          cnt_nxt    = '0;
          cnt_nxt[0] = 1'b1;
          wrap_nxt   = 1'b1;
          sat_nxt    = 1'b0;
        end else begin
          cnt_nxt = bus.rollover_val;
          sat_nxt = 1'b1;
        end
      end else if (bus.count_up) begin
        if (bus.wrap_mode) begin
          sat_nxt = 1'b0;
          if (sum_w > r_w) begin
            res_w    = sum_w - r_w;
            wrap_nxt = 1'b1;
          end else begin
            res_w = sum_w;
          end
          cnt_nxt = res_w[W-1:0];
        end else if (sum_w >= r_w) begin
          cnt_nxt = bus.rollover_val;
          sat_nxt = 1'b1;
        end else begin
          cnt_nxt = sum_w[W-1:0];
          sat_nxt = 1'b0;
        end
      end else begin
        if (bus.wrap_mode) begin
          sat_nxt = 1'b0;
          if (cp_w > s_w) begin
            res_w = cp_w - s_w;
          end else begin
            res_w    = cp_w + r_w - s_w;
            wrap_nxt = 1'b1;
          end
          cnt_nxt = res_w[W-1:0];
        end else if (c_w <= s_w) begin
          cnt_nxt = '0;
          sat_nxt = 1'b1;
        end else begin
          res_w   = c_w - s_w;
          cnt_nxt = res_w[W-1:0];
          sat_nxt = 1'b0;
        end
      end
    end
  end

  // State and status registers; rollover_flag is registered against the R
  // sampled on the same edge so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
      flag_q  <= (bus.rollover_val == '0);
    end else begin
      count_q <= cnt_nxt;
      wrap_q  <= wrap_nxt;
      sat_q   <= sat_nxt;
      flag_q  <= (cnt_nxt == bus.rollover_val);
    end
  end

  assign bus.count_out     = count_q;
  assign bus.rollover_flag = flag_q;
  assign bus.wrap_pulse    = wrap_q;
  assign bus.saturated     = sat_q;
endmodule

// File: tb/tb_flex_counter_mode.sv
// Bench for flex_counter_mode: directed vector table from the test plan,
// then randomized traffic compared against an arithmetic reference model.
module tb_flex_counter_mode;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flex_counter_mode_if #(.NUM_CNT_BITS(W)) bus ();
  flex_counter_mode #(.NUM_CNT_BITS(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic         rst, clr, ld;
    logic [W-1:0] lv;
    logic         en, up, wr;
    logic [W-1:0] st, r;
    int           e_cnt;
    logic         e_flag, e_wp, e_sat;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  // Reference model state.
  int m_cnt = 0;
  bit m_wp = 0, m_sat = 0, m_flag = 0;

  task automatic add(input bit r, input bit c, input bit l, input int lv,
                     input bit en, input bit up, input bit wr, input int st,
                     input int rv, input int ec, input bit ef, input bit ew,
                     input bit es);
    vec_t v;
    v.rst = r; v.clr = c; v.ld = l; v.lv = W'(lv);
    v.en = en; v.up = up; v.wr = wr; v.st = W'(st); v.r = W'(rv);
    v.e_cnt = ec; v.e_flag = ef; v.e_wp = ew; v.e_sat = es;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Behavioural model: the ring 1..R treated with modular arithmetic.
  task automatic model_step(input vec_t v);
    int R, s, c, cp, lv;
    R = int'(v.r); c = m_cnt; lv = int'(v.lv);
    if (v.rst) begin
      m_cnt = 0; m_wp = 0; m_sat = 0;
    end else if (v.clr) begin
      m_cnt = 0; m_wp = 0; m_sat = 0;
    end else if (v.ld) begin
      m_cnt = (lv < R) ? lv : R; m_wp = 0; m_sat = 0;
    end else if (v.en && R != 0) begin
      s = (v.st == 0) ? 1 : ((int'(v.st) > R) ? R : int'(v.st));
      m_wp = 0;
      if (c > R) begin
        if (v.wr) begin m_cnt = 1; m_wp = 1; m_sat = 0; end
        else begin m_cnt = R; m_sat = 1; end
      end else if (v.up) begin
        if (v.wr) begin
          m_wp = (c + s > R); m_cnt = ((c + s - 1) % R) + 1; m_sat = 0;
        end else if (c + s >= R) begin m_cnt = R; m_sat = 1; end
        else begin m_cnt = c + s; m_sat = 0; end
      end else begin
        if (v.wr) begin
          cp = (c == 0) ? R : c;
          m_wp = (cp <= s);
          m_cnt = (((cp - s - 1) % R) + R) % R + 1;
          m_sat = 0;
        end else if (c <= s) begin m_cnt = 0; m_sat = 1; end
        else begin m_cnt = c - s; m_sat = 0; end
      end
    end else begin
      m_wp = 0;
    end
    m_flag = (m_cnt == R);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst              = v.rst;
    bus.clear        = v.clr;
    bus.load         = v.ld;
    bus.load_val     = v.lv;
    bus.count_enable = v.en;
    bus.count_up     = v.up;
    bus.wrap_mode    = v.wr;
    bus.step_val     = v.st;
    bus.rollover_val = v.r;
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  initial begin
    vec_t v;
    int   cur_r, cur_st;
    rst = 1'b1;
    bus.clear = 0; bus.load = 0; bus.load_val = '0; bus.count_enable = 0;
    bus.count_up = 1; bus.wrap_mode = 1; bus.step_val = 8'd1; bus.rollover_val = 8'd5;

    // 1: reset then R=5 up wrap step 1
    //  rst clr ld lv en up wr st R  cnt flag wp sat
    add(1, 0, 0, 0, 0, 1, 1, 1, 5,  0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 1, 1, 5,  0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 1, 5,  1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 1, 5,  2, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 1, 5,  3, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 1, 5,  4, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 1, 5,  5, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 1, 5,  1, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1, 1, 1, 5,  2, 0, 0, 0);
    // 2: R=10 step 4 up wrap, then step 0
    add(0, 1, 0, 0, 0, 1, 1, 4, 10, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 4, 10, 4, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 4, 10, 8, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 4, 10, 2, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1, 1, 4, 10, 6, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 4, 10, 10, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 4, 10, 4, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1, 1, 0, 10, 5, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 0, 10, 6, 0, 0, 0);
    // 3: load 3, R=7 down wrap s=2, then saturate s=5, then up s=1
    add(0, 0, 1, 3, 0, 0, 1, 2, 7,  3, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 1, 2, 7,  1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 1, 2, 7,  6, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 1, 2, 7,  4, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 5, 7,  0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 5, 7,  0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 0, 1, 7,  1, 0, 0, 0);
    // 4: R=12 s=5 up saturate, then clear
    add(0, 1, 0, 0, 0, 1, 0, 5, 12, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 5, 12, 5, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 5, 12, 10, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 5, 12, 12, 1, 0, 1);
    add(0, 0, 0, 0, 1, 1, 0, 5, 12, 12, 1, 0, 1);
    add(0, 1, 0, 0, 0, 1, 0, 5, 12, 0, 0, 0, 0);
    // 5: priority
    add(0, 1, 1, 9, 1, 1, 1, 1, 15, 0, 0, 0, 0);
    add(0, 0, 1, 20, 0, 1, 1, 1, 15, 15, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 1, 15, 1, 0, 1, 0);
    add(0, 0, 1, 20, 1, 1, 1, 1, 15, 15, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 1, 15, 1, 0, 1, 0);
    add(1, 1, 1, 20, 1, 1, 1, 1, 15, 0, 0, 0, 0);
    // 6: out-of-range after lowering R, then R=0
    add(0, 0, 1, 9, 0, 1, 1, 1, 12, 9, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 1, 6,  1, 0, 1, 0);
    add(0, 0, 1, 9, 0, 1, 0, 1, 12, 9, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 6,  6, 1, 0, 1);
    add(0, 0, 0, 0, 1, 1, 1, 1, 0,  6, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 1, 1, 0,  6, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1, 1, 1, 0,  0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 1, 1, 0,  0, 1, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i]);
      check($sformatf("vec%0d count_out", i), int'(bus.count_out), vecs[i].e_cnt);
      check($sformatf("vec%0d rollover_flag", i), int'(bus.rollover_flag), int'(vecs[i].e_flag));
      check($sformatf("vec%0d wrap_pulse", i), int'(bus.wrap_pulse), int'(vecs[i].e_wp));
      check($sformatf("vec%0d saturated", i), int'(bus.saturated), int'(vecs[i].e_sat));
    end

    // Randomized traffic against the reference model.
    cur_r = 9; cur_st = 1;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0)
        cur_r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0)
        cur_st = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      v.rst = ($urandom_range(0, 63) == 0);
      v.clr = ($urandom_range(0, 31) == 0);
      v.ld  = ($urandom_range(0, 15) == 0);
      v.lv  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 18));
      v.en  = ($urandom_range(0, 3) != 0);
      v.up  = ($urandom_range(0, 2) != 0);
      v.wr  = ($urandom_range(0, 3) != 0);
      v.st  = W'(cur_st);
      v.r   = W'(cur_r);
      v.e_cnt = 0; v.e_flag = 0; v.e_wp = 0; v.e_sat = 0;
      apply(v);
      check($sformatf("rnd%0d count_out", k), int'(bus.count_out), m_cnt);
      check($sformatf("rnd%0d rollover_flag", k), int'(bus.rollover_flag), int'(m_flag));
      check($sformatf("rnd%0d wrap_pulse", k), int'(bus.wrap_pulse), int'(m_wp));
      check($sformatf("rnd%0d saturated", k), int'(bus.saturated), int'(m_sat));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/flex_counter_mode.md
Name: flex_counter_mode

Overview:
- Parametrised successor to the team's basic flexible counter, used for bit and byte timing and timeout generation in the serial receiver/transmitter datapaths.
- Adds up/down direction, a programmable step size, a synchronous load, and a wrap vs. saturate mode.
- Adds separate level and pulse status outputs.
- Counting range is the ring 1..rollover_val. A count of 0 occurs only after reset, clear, load or a down-saturate.

Parameters:
NUM_CNT_BITS, 8, width of count, load, step and rollover values

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high; sampled on rising edge of clk
clear  input  1  synchronous clear of count and status
load  input  1  synchronous load of load_val
load_val  input  NUM_CNT_BITS  value loaded when load=1
count_enable  input  1  advance count by one step this cycle
count_up  input  1  direction: 1 = up, 0 = down
wrap_mode  input  1  1 = wrap within 1..rollover_val; 0 = saturate
step_val  input  NUM_CNT_BITS  increment/decrement amount
rollover_val  input  NUM_CNT_BITS  ring upper bound R
count_out  output  NUM_CNT_BITS  registered count
rollover_flag  output  1  high while count_out == rollover_val
wrap_pulse  output  1  one-cycle pulse in the cycle after a wrap occurred
saturated  output  1  high in the cycle after a clamped update; held until next non-clamped update

Behaviour:
- All outputs are registered, or decoded only from registered state. There are no combinational paths from inputs to outputs.
- Reset values: count_out=0, rollover_flag=0 (unless R==0, see below), wrap_pulse=0, saturated=0. A reset mid-operation overrides everything in the same edge.
- Priority per edge is rst > clear > load > count_enable > hold.
- clear:
  - count_out <= 0; wrap_pulse <= 0; saturated <= 0.
- load:
  - count_out <= min(load_val, R); wrap_pulse <= 0; saturated <= 0.
  - A load with load_val > R clamps to R.
- hold (count_enable=0): count_out unchanged; wrap_pulse <= 0; saturated unchanged.
- Effective step s:
  - s = 1 if step_val == 0.
  - s = R if step_val > R.
  - Otherwise s = step_val.
- R == 0: enabled updates are ignored (count held, wrap_pulse <= 0). clear, load and rst still act. rollover_flag is high only if count_out == 0.
- Out-of-range (count_out > R at an enabled update, e.g. after R was lowered):
  - Wrap mode: next = 1, wrap_pulse <= 1.
  - Saturate mode: next = R, saturated <= 1.
  - Direction is ignored in this case.
- Arithmetic is done in NUM_CNT_BITS+1 bits; no intermediate overflow is permitted.
- Up, wrap: sum = c + s. If sum > R, then next = sum − R and wrap_pulse <= 1; else next = sum.
- Up, saturate: if c + s >= R, then next = R and saturated <= 1; else next = c + s and saturated <= 0.
- Down, wrap: let c' = R if c == 0, else c. If c' > s, then next = c' − s; else next = c' + R − s and wrap_pulse <= 1.
- Down, saturate: if c <= s, then next = 0 and saturated <= 1; else next = c − s and saturated <= 0.
- Status outputs:
  - wrap_pulse is never high for two consecutive cycles unless a wrap occurs on consecutive enabled updates.
  - saturated is always 0 after any update made in wrap mode.
  - rollover_flag = (count_out == R), evaluated on the current R, independent of direction and mode.
- Changing count_up, wrap_mode, step_val or rollover_val takes effect on the next enabled edge, with no internal pipeline.
- Latency: an input change is visible on count_out and status one cycle after the sampling edge.

Test Plan:
1. Reset / basic count: rst=1 for 2 cycles, then R=5, s=1, up, wrap, enable continuously.
   - Required: count_out 0,1,2,3,4,5,1,2...
   - rollover_flag high exactly while count_out=5.
   - wrap_pulse high one cycle coincident with the first count_out=1 after 5.
2. Step wrap up: R=10, step_val=4, wrap, up, starting from 0.
   - Required: 4,8,2 (wrap_pulse), 6,10 (rollover_flag), 4 (wrap_pulse).
   - Then set step_val=0: count advances by 1.
3. Down wrap and saturate: load 3 with R=7.
   - Down, wrap, s=2: 3 → 1 → 6 (wrap_pulse) → 4.
   - Then wrap_mode=0, s=5: 4 → 0 with saturated=1.
   - Further enables hold at 0 with saturated=1.
   - Then switch to up, s=1: 1, saturated=0.
4. Up saturate: R=12, s=5, up, saturate, from 0.
   - Required: 5,10,12 (saturated=1, rollover_flag=1), 12 held.
   - Then clear=1: count_out=0, saturated=0.
5. Priority and simultaneity:
   - clear=1, load=1, enable=1 in same cycle → count_out=0.
   - load=1 with load_val=20, R=15, enable=1 → count_out=15 (clamped), wrap_pulse=0.
   - rst=1 asserted together with all of the above → all outputs at reset values.
6. Out-of-range and R=0:
   - Count to 9 with R=12, then lower R to 6 with an enable → count_out=1, wrap_pulse=1 (wrap mode); count_out=6, saturated=1 (saturate mode).
   - Set R=0 with enable held → count unchanged, wrap_pulse=0.
